ram_arbiter: RTL
================

// Module: ram_arbiter
// PURPOSE
//  Two-requester arbiter/sequencer in front of the single-port word RAM (cs/write, comb. read, sync write).
//  Port 0 = instruction fetch, port 1 = data load/store. Each access is latched, driven to the RAM
//  for exactly one cycle, then answered with a registered done pulse and, for reads, registered data.
//  Sits between the core front-end/LSU and the RAM instance.
// PARAMETERS
//  BUS_WIDTH  32  data width of requesters and RAM
//  ADDR_W     32  word-address width passed straight to RAM addr
// PORTS
//  clk        in   1          clock, all state on posedge
//  rst_n      in   1          async active-low reset
//  req        in   2          per-port request, held until gnt seen
//  we         in   2          per-port write enable (1=store, 0=load)
//  addr0      in   ADDR_W     port 0 word address
//  addr1      in   ADDR_W     port 1 word address
//  wdata0     in   BUS_WIDTH  port 0 write data
//  wdata1     in   BUS_WIDTH  port 1 write data
//  gnt        out  2          one-hot, high during the RAM access cycle of the owner
//  done       out  2          one-hot 1-cycle pulse, cycle after access (read and write)
//  rdata      out  BUS_WIDTH  registered read data, valid when done[i] && access was a read
//  ram_cs     out  1          RAM chip select
//  ram_write  out  1          RAM write strobe
//  ram_addr   out  ADDR_W     RAM address
//  ram_wdata  out  BUS_WIDTH  RAM write data
//  ram_rdata  in   BUS_WIDTH  RAM read data (high-Z when not reading; sampled only in ACCESS read)
// BEHAVIOUR
//  Reset: state=IDLE; gnt=0, done=0, rdata=0, ram_cs=0, ram_write=0, ram_addr=0, ram_wdata=0,
//   last_owner=1. Reset is async: ram_cs/ram_write drop immediately, so an in-flight write is lost.
//  FSM IDLE -> ACCESS -> IDLE. Throughput 1 access / 2 cycles; latency req->done = 2 edges.
//  IDLE: if |req at posedge: pick owner, latch owner/we/addr/wdata, -> ACCESS. No req: stay IDLE.
//  ACCESS (1 cycle): ram_cs=1, ram_write=lat_we, ram_addr=lat_addr, ram_wdata=lat_wdata,
//   gnt[owner]=1 (all registered, no comb. path req->RAM). At closing edge: write commits in RAM;
//   read: rdata<=ram_rdata; done[owner]<=1; last_owner<=owner; -> IDLE.
//  Outside ACCESS: ram_cs=0, ram_write=0; ram_addr/ram_wdata hold last value; rdata holds until next read.
//  done is 1 cycle only; coincides with IDLE and may overlap a new request being sampled.
//  Handshake: requester drops req (or changes it for a new access) on the edge ending gnt;
//   req still high in next IDLE = new access. Inputs must be stable from req rise until gnt.
//  Requests arriving during ACCESS are not sampled until IDLE; no queuing, no loss while held.
//  Arbitration (single req): that port. Both req: per CONFIGURATION.
//  Address passed unmodified; range checking is the RAM's/system's concern.
// CONFIGURATION
//  RAM_ARB_RR_EN defined: round-robin, on conflict grant port != last_owner (first conflict after
//   reset -> port 0). Undefined: fixed priority, port 1 (data) always wins; port 0 may starve.
// TESTING
//  Reset: rst_n=0 mid-ACCESS write of 0xDEADBEEF @0x10 -> ram_cs=0 at once, all outputs 0, mem[0x10] unchanged.
//  Single read: req=01, addr0=0x4, mem[4]=0x12345678 -> gnt=01 next cycle, ram_cs=1 ram_write=0,
//   then done=01, rdata=0x12345678.
//  Write then read: port1 we=1 addr1=0x20 wdata1=0xCAFEF00D, then port1 read 0x20 -> rdata=0xCAFEF00D,
//   done pulses 2 cycles apart per access, gnt/done never 2'b11.
//  Conflict, RR_EN: req=11 held 4 accesses -> owner order 0,1,0,1; done pulses every 2 cycles.
//  Conflict, RR_EN undefined: req=11 held 3 accesses -> owner 1,1,1; port 0 granted only after req[1]=0.
//  Back-to-back: port0 reads 0x0..0x7 keeping req high -> 8 done pulses, 16 cycles, data in order.

Source files
------------

// File: rtl/ram_arbiter.sv
// Two-port arbiter/sequencer for a single-port word RAM: port 0 = instruction fetch, port 1 = data.
// Define RAM_ARB_RR_EN for round-robin on conflict; otherwise port 1 has fixed priority.
module ram_arbiter #(
  parameter int BUS_WIDTH = 32,
  parameter int ADDR_W    = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [1:0]           req,
  input  logic [1:0]           we,
  input  logic [ADDR_W-1:0]    addr0,
  input  logic [ADDR_W-1:0]    addr1,
  input  logic [BUS_WIDTH-1:0] wdata0,
  input  logic [BUS_WIDTH-1:0] wdata1,
  output logic [1:0]           gnt,
  output logic [1:0]           done,
  output logic [BUS_WIDTH-1:0] rdata,
  output logic                 ram_cs,
  output logic                 ram_write,
  output logic [ADDR_W-1:0]    ram_addr,
  output logic [BUS_WIDTH-1:0] ram_wdata,
  input  logic [BUS_WIDTH-1:0] ram_rdata
);

  typedef enum logic [0:0] {
    ST_IDLE   = 1'b0,
    ST_ACCESS = 1'b1
  } state_t;

  state_t                 state_r;
  logic                   lat_owner_r;
  logic                   lat_we_r;
  logic                   owner_s;
  logic                   owner_we_s;
  logic [ADDR_W-1:0]      owner_addr_s;
  logic [BUS_WIDTH-1:0]   owner_wdata_s;
`ifdef RAM_ARB_RR_EN
  logic                   last_owner_r;
`endif

  // Owner selection among the currently requesting ports
  always_comb begin
    owner_s = 1'b0;
    if (req == 2'b11) begin
`ifdef RAM_ARB_RR_EN
      owner_s = ~last_owner_r;
`else
      owner_s = 1'b1;
`endif
    end else if (req[1]) begin
      owner_s = 1'b1;
    end else begin
      owner_s = 1'b0;
    end
  end

  // Route the selected port's command fields
  always_comb begin
    owner_we_s    = we[0];
    owner_addr_s  = addr0;
    owner_wdata_s = wdata0;
    if (owner_s) begin
      owner_we_s    = we[1];
      owner_addr_s  = addr1;
      owner_wdata_s = wdata1;
    end else begin
      owner_we_s    = we[0];
      owner_addr_s  = addr0;
      owner_wdata_s = wdata0;
    end
  end

  // Sequencer: latch the command in IDLE, drive the RAM for one ACCESS cycle, then answer
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r      <= ST_IDLE;
      lat_owner_r  <= 1'b0;
      lat_we_r     <= 1'b0;
      gnt          <= 2'b00;
      done         <= 2'b00;
      rdata        <= {BUS_WIDTH{1'b0}};
      ram_cs       <= 1'b0;
      ram_write    <= 1'b0;
      ram_addr     <= {ADDR_W{1'b0}};
      ram_wdata    <= {BUS_WIDTH{1'b0}};
`ifdef RAM_ARB_RR_EN
      last_owner_r <= 1'b1;
`endif
    end else begin
      done <= 2'b00;
      case (state_r)
        ST_IDLE: begin
          if (|req) begin
            state_r     <= ST_ACCESS;
            lat_owner_r <= owner_s;
            lat_we_r    <= owner_we_s;
            ram_cs      <= 1'b1;
            ram_write   <= owner_we_s;
            ram_addr    <= owner_addr_s;
            ram_wdata   <= owner_wdata_s;
            gnt         <= owner_s ? 2'b10 : 2'b01;
          end else begin
            state_r   <= ST_IDLE;
            ram_cs    <= 1'b0;
            ram_write <= 1'b0;
            gnt       <= 2'b00;
          end
        end
        ST_ACCESS: begin
          // ram_addr/ram_wdata intentionally keep their last value after the access
          state_r   <= ST_IDLE;
          ram_cs    <= 1'b0;
          ram_write <= 1'b0;
          gnt       <= 2'b00;
          done      <= lat_owner_r ? 2'b10 : 2'b01;
          if (!lat_we_r) begin
            rdata <= ram_rdata;
          end else begin
            rdata <= rdata;
          end
`ifdef RAM_ARB_RR_EN
          last_owner_r <= lat_owner_r;
`endif
        end
        default: begin
          state_r   <= ST_IDLE;
          ram_cs    <= 1'b0;
          ram_write <= 1'b0;
          gnt       <= 2'b00;
        end
      endcase
    end
  end

endmodule
